// File: rtl/spi_slave_if.sv
// SPI slave front end: MOSI frames -> 10-bit RAM commands, RAM read data -> MISO.
// Optional SPI_FRAME_ERR_EN: one-cycle frame_err strobe on an aborted frame.
module spi_slave_if #(
   parameter int RX_WIDTH = 10,
   parameter int TX_WIDTH = 8
) (
   input  logic                CLK,
   input  logic                rst_n,
   input  logic                SS_n,
   input  logic                MOSI,
   output logic                MISO,
   output logic [RX_WIDTH-1:0] rx_data,
   output logic                rx_valid,
   input  logic [TX_WIDTH-1:0] tx_data,
   input  logic                tx_valid,
   output logic                frame_err
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;

   localparam logic [3:0] RX_LAST = 4'(RX_WIDTH - 1);
   localparam logic [3:0] TX_LAST = 4'(TX_WIDTH - 1);
   localparam logic [3:0] TX_DONE = 4'(TX_WIDTH);

   logic [2:0]          state;
   logic [3:0]          cnt;
   logic [3:0]          tx_cnt;
   logic                rx_done;
   logic                rd_addr_ok;
   logic [RX_WIDTH-2:0] rx_sh;
   logic [TX_WIDTH-2:0] tx_sh;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         tx_cnt     <= '0;
         rx_done    <= 1'b0;
         rd_addr_ok <= 1'b0;
         rx_sh      <= '0;
         tx_sh      <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         MISO       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_cnt  <= '0;
            rx_done <= 1'b0;
            tx_sh   <= '0;
            MISO    <= 1'b0;
         end else begin
            unique case (state)
               IDLE: state <= CHK_CMD;
               CHK_CMD: begin
                  rx_sh <= {rx_sh[RX_WIDTH-3:0], MOSI};
                  cnt   <= 4'd1;
                  if (!MOSI)
                     state <= WRITE;
                  else if (rd_addr_ok)
                     state <= READ_DATA;
                  else
                     state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (!rx_done) begin
                     if (cnt == RX_LAST) begin
                        rx_data  <= {rx_sh, MOSI};
                        rx_valid <= 1'b1;
                        rx_done  <= 1'b1;
                        if (state == READ_ADD)
                           rd_addr_ok <= 1'b1;
                     end else begin
                        rx_sh <= {rx_sh[RX_WIDTH-3:0], MOSI};
                        cnt   <= cnt + 4'd1;
                     end
                  end else if (state == READ_DATA) begin
                     // tx_cnt: 0 awaiting RAM data, 1..7 shifting, 8 done
                     if (tx_cnt == 4'd0) begin
                        if (tx_valid && !rx_valid) begin
                           MISO   <= tx_data[TX_WIDTH-1];
                           tx_sh  <= tx_data[TX_WIDTH-2:0];
                           tx_cnt <= 4'd1;
                        end
                     end else if (tx_cnt == TX_DONE) begin
                        MISO <= 1'b0;
                     end else begin
                        MISO   <= tx_sh[TX_WIDTH-2];
                        tx_sh  <= tx_sh << 1;
                        tx_cnt <= tx_cnt + 4'd1;
                        if (tx_cnt == TX_LAST)
                           rd_addr_ok <= 1'b0;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SPI_FRAME_ERR_EN
   logic abort;
   assign abort = (state != IDLE) &&
                  (!rx_done ||
                   (state == READ_DATA && tx_cnt != TX_DONE));

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n)
         frame_err <= 1'b0;
      else
         frame_err <= SS_n && abort;
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// Scoreboard bench for spi_slave_if: expected words/bits queued
// on stimulus, popped when the slave produces them.
module tb_spi_slave_if;

   logic       CLK = 1'b0;
   logic       rst_n = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       frame_err;

`ifdef SPI_FRAME_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   int passed = 0;
   int total  = 0;
   logic [9:0] exp_rx[$];
   logic       exp_miso[$];

   always #5 CLK = ~CLK;

   spi_slave_if dut (
      .CLK(CLK), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
      .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .frame_err(frame_err)
   );

   // Full frame; returns at the negedge after E11 with SS_n still low.
   task automatic send_word(input logic [9:0] w);
      logic [9:0] e;
      exp_rx.push_back(w);
      @(negedge CLK);
      SS_n = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         @(negedge CLK);
         MOSI = w[i];
      end
      @(negedge CLK);
      total++;
      e = exp_rx.pop_front();
      if (rx_valid !== 1'b1 || rx_data !== e)
         $display("FAIL rx_word: valid=%b data=%h expected valid=1 data=%h",
                  rx_valid, rx_data, e);
      else
         passed++;
      @(negedge CLK);
      total++;
      if (rx_valid !== 1'b0)
         $display("FAIL rx_pulse_len: rx_valid=%b expected 0", rx_valid);
      else
         passed++;
   endtask

   // RAM answer after d idle cycles, then check the 8 MISO bits.
   task automatic read_byte(input logic [7:0] b, input int d,
                            input logic second);
      logic eb;
      for (int i = 0; i < d; i++) begin
         total++;
         if (MISO !== 1'b0)
            $display("FAIL miso_wait: MISO=%b expected 0 (cycle %0d)", MISO, i);
         else
            passed++;
         @(negedge CLK);
      end
      tx_data  = b;
      tx_valid = 1'b1;
      for (int k = 7; k >= 0; k--) exp_miso.push_back(b[k]);
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         if (k == 0) tx_valid = 1'b0;
         if (k == 3 && second) begin
            tx_valid = 1'b1;
            tx_data  = ~b;
         end
         if (k == 4) tx_valid = 1'b0;
         eb = exp_miso.pop_front();
         total++;
         if (MISO !== eb)
            $display("FAIL miso_bit%0d: MISO=%b expected %b", 7 - k, MISO, eb);
         else
            passed++;
      end
      @(negedge CLK);
      total++;
      if (MISO !== 1'b0)
         $display("FAIL miso_after: MISO=%b expected 0", MISO);
      else
         passed++;
   endtask

   task automatic test_reset();
      #3;
      total++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0 ||
          rx_data !== 10'h000 || frame_err !== 1'b0)
         $display("FAIL reset_state: MISO=%b rx_valid=%b rx_data=%h err=%b expected all 0",
                  MISO, rx_valid, rx_data, frame_err);
      else
         passed++;
      @(negedge CLK);
      rst_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_write();
      send_word(10'h03A);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      @(negedge CLK);
      tx_valid = 1'b0;
      total++;
      if (MISO !== 1'b0)
         $display("FAIL write_miso: MISO=%b expected 0", MISO);
      else
         passed++;
      SS_n = 1'b1;
      @(negedge CLK);
      total++;
      if (frame_err !== 1'b0)
         $display("FAIL write_err: frame_err=%b expected 0", frame_err);
      else
         passed++;
      send_word(10'h1C5);
      SS_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_read();
      send_word(10'h23A);
      SS_n = 1'b1;
      send_word(10'h300);
      read_byte(8'hC5, 0, 1'b1);
      SS_n = 1'b1;
      @(negedge CLK);
      total++;
      if (frame_err !== 1'b0)
         $display("FAIL read_err: frame_err=%b expected 0", frame_err);
      else
         passed++;
   endtask

   // rd_addr_ok cleared: a 1_1 frame is a read-address frame, no MISO.
   task automatic test_rd_flag();
      logic bad;
      bad = 1'b0;
      send_word(10'h300);
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         tx_valid = 1'b0;
         if (MISO !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad)
         $display("FAIL rd_flag_miso: MISO went 1 expected 0 (flag not cleared)");
      else
         passed++;
      SS_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_delay();
      send_word(10'h300);
      read_byte(8'h96, 3, 1'b0);
      SS_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_abort();
      logic [9:0] w;
      w = 10'h0F3;
      @(negedge CLK);
      SS_n = 1'b0;
      for (int i = 9; i >= 4; i--) begin
         @(negedge CLK);
         MOSI = w[i];
      end
      @(negedge CLK);
      SS_n = 1'b1;
      @(negedge CLK);
      total++;
      if (frame_err !== EXP_ERR || rx_valid !== 1'b0)
         $display("FAIL abort_err: frame_err=%b rx_valid=%b expected err=%b valid=0",
                  frame_err, rx_valid, EXP_ERR);
      else
         passed++;
      @(negedge CLK);
      total++;
      if (frame_err !== 1'b0 || rx_valid !== 1'b0)
         $display("FAIL abort_pulse: frame_err=%b rx_valid=%b expected 0 0",
                  frame_err, rx_valid);
      else
         passed++;
      send_word(10'h0A5);
      SS_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      send_word(10'h155);
      SS_n = 1'b1;
      send_word(10'h0C3);
      SS_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_async_reset();
      logic bad;
      bad = 1'b0;
      send_word(10'h23A);
      SS_n = 1'b1;
      send_word(10'h300);
      tx_data  = 8'hF0;
      tx_valid = 1'b1;
      @(negedge CLK);
      tx_valid = 1'b0;
      total++;
      if (MISO !== 1'b1)
         $display("FAIL areset_pre: MISO=%b expected 1", MISO);
      else
         passed++;
      @(posedge CLK);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (MISO !== 1'b0 || rx_valid !== 1'b0)
         $display("FAIL areset_now: MISO=%b rx_valid=%b expected 0 0",
                  MISO, rx_valid);
      else
         passed++;
      SS_n = 1'b1;
      @(negedge CLK);
      rst_n = 1'b1;
      send_word(10'h300);
      tx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         tx_valid = 1'b0;
         if (MISO !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad)
         $display("FAIL areset_flag: MISO went 1 expected 0 (rd_addr_ok kept)");
      else
         passed++;
      SS_n = 1'b1;
      @(negedge CLK);
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_rd_flag();
      test_delay();
      test_abort();
      test_back_to_back();
      test_async_reset();
      total++;
      if (exp_rx.size() != 0 || exp_miso.size() != 0)
         $display("FAIL scoreboard_left: rx=%0d miso=%0d expected 0 0",
                  exp_rx.size(), exp_miso.size());
      else
         passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front end of the SPI-slave-to-RAM path: converts an SPI bit stream (SS_n, MOSI) into 10-bit command words for the single-port RAM (rx_data/rx_valid), and returns 8-bit RAM read data (tx_data/tx_valid) serially on MISO. It sits directly upstream of the RAM, which consumes rx_data[9:8] as control and rx_data[7:0] as address/data. A Moore FSM tracks frame type and read sequencing; all logic is in the CLK domain, and SCK is CLK.

## Interface
Parameters:
- RX_WIDTH, 10, command word width (control 2 + payload 8).
- TX_WIDTH, 8, read-data width returned on MISO.

Ports:
- CLK  in  1  system clock; also the SPI bit clock.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low; frames bounded by SS_n low.
- MOSI  in  1  serial data in, sampled on CLK rising edge, MSB first.
- MISO  out  1  serial data out, registered, MSB first.
- rx_data  out  RX_WIDTH  assembled command word to RAM.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  TX_WIDTH  read data from RAM.
- tx_valid  in  1  tx_data valid strobe from RAM.
- frame_err  out  1  one-cycle strobe on aborted frame (see Configuration).

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal flag rd_addr_ok.
- IDLE: SS_n=0 at a rising edge -> CHK_CMD. No bit is sampled on this edge (dummy cycle).
- CHK_CMD: samples MOSI as rx bit 9 and shifts it in.
  - MOSI=0 -> WRITE.
  - MOSI=1 with rd_addr_ok=0 -> READ_ADD.
  - MOSI=1 with rd_addr_ok=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: shift 9 more MOSI bits, one per cycle (bits 8..0). The 4-bit counter counts 0..9 across CHK_CMD plus the data state.
- After bit 0 is sampled: rx_data is loaded with the full word and rx_valid=1 for exactly one cycle.
- READ_ADD completion sets rd_addr_ok.
- READ_DATA, after rx_valid: waits for tx_valid, then captures tx_data and shifts it out on MISO, 8 bits.
  - rd_addr_ok clears when the 8th bit has been driven.
  - The FSM then holds in READ_DATA until SS_n=1.
- WRITE and READ_ADD: after completion, extra MOSI bits are ignored until SS_n=1.
- SS_n=1 in any state: next state IDLE, bit counter and MISO shifter cleared, MISO=0. rx_valid is not issued for an incomplete word; rd_addr_ok is unchanged.
- tx_valid is ignored outside READ_DATA-awaiting-data. A second tx_valid during shifting is ignored.
- The control bits rx_data[9:8] are passed through unchecked; the RAM decodes them.
- Reset values: state IDLE, rx_data=0, rx_valid=0, MISO=0, frame_err=0, rd_addr_ok=0, counters 0.

## Timing
- Frame: SS_n falls; edge E0 is the dummy; edges E1..E10 sample bits 9..0.
- rx_valid is high in the cycle after E10 and seen by the RAM at E11.
- RAM tx_valid is high after E11. The slave samples it at E12 and drives MISO=tx_data[7] from E12. tx_data[6..0] follow on E13..E19.
- MISO returns to 0 at E20.
- Minimum SS_n-low cycles: write/read-address frame 11 edges; read-data frame 20 edges.
- If tx_valid arrives later than E12, shifting starts on the edge where it is sampled.
- rst_n asserted mid-frame: all state returns to reset values immediately (asynchronous). On release, the block waits in IDLE; if SS_n is already low, a new frame starts with a dummy cycle.

## Configuration
- SPI_FRAME_ERR_EN defined: frame_err pulses for one cycle (the cycle after SS_n is sampled high) when SS_n rises in either of these cases:
  - in CHK_CMD/WRITE/READ_ADD/READ_DATA before bit 0 was sampled;
  - in READ_DATA before the 8th MISO bit was driven.
- SPI_FRAME_ERR_EN undefined: frame_err is tied 0; all other behaviour is identical.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle -> MISO=0, rx_valid=0, state IDLE immediately.
- Write-address frame: SS_n low, bits 0_0_0x3A -> one rx_valid with rx_data=0x03A at E11; MISO stays 0.
- Write-data frame: bits 0_1_0xC5 -> rx_data=0x1C5, one rx_valid; RAM mem[0x3A]=0xC5.
- Read-address then read-data: bits 1_0_0x3A -> rx_data=0x23A and rd_addr_ok=1; then bits 1_1_0x00 -> rx_data=0x300, RAM tx_valid -> MISO serialises 1,1,0,0,0,1,0,1 on E12..E19; rd_addr_ok=0 after.
- Abort: SS_n high after 5 data bits -> no rx_valid, state IDLE; frame_err=1 for one cycle only with SPI_FRAME_ERR_EN; next full frame decodes correctly.
- Read-data with tx_valid delayed 3 cycles -> MISO MSB starts on the edge sampling tx_valid; MISO=0 while waiting.
